icache_direct_mapped: RTL
=========================

// Module: icache_direct_mapped
// PURPOSE
//  Direct-mapped instruction cache between the datapath fetch stage (imemREN/imemaddr in,
//  ihit/imemload out) and the memory controller (iREN/iaddr out, iwait/iload in).
//  Hits return in the same cycle. Misses refill one whole block, word by word, under a
//  small FSM; after the refill the access hits. Read-only: no write or dirty path.
// PARAMETERS
//  SETS         16  number of cache lines; power of 2, >=2
//  BLOCK_WORDS  2   32-bit words per line; power of 2, >=1
// PORTS
//  CLK        in   1   clock; all state updates on rising edge
//  RST        in   1   reset
//  imemREN    in   1   fetch request from datapath
//  imemaddr   in   32  fetch byte address; word aligned, bits[1:0] ignored
//  ihit       out  1   requested word valid on imemload this cycle
//  imemload   out  32  instruction word
//  iREN       out  1   memory read request
//  iaddr      out  32  memory word address, bits[1:0]=0
//  iwait      in   1   memory busy; iload valid in a cycle with iREN=1 and iwait=0
//  iload      in   32  memory read data
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - RST=1: all valid bits clear, state=IDLE, word counter=0; ihit=0, imemload=0, iREN=0, iaddr=0.
//    Tag and data arrays are not reset. RST mid-refill abandons the refill; nothing installed.
//  - Address split: [1:0] byte, next WOFF=$clog2(BLOCK_WORDS) bits word offset,
//    next IDX=$clog2(SETS) bits index, remaining upper bits tag. WOFF=0 when BLOCK_WORDS=1.
//  - IDLE: hit = imemREN & valid[idx] & (tag[idx]==addr tag). ihit=hit and imemload=data[idx][woff],
//    both combinational, so hit latency is 0 cycles. imemload=0 whenever ihit=0.
//    If imemREN=1 and there is no hit: latch the miss tag and index, clear the counter, and go to REFILL.
//  - REFILL: iREN=1 and iaddr={miss tag, miss idx, counter, 2'b00}. ihit=0 for every address.
//    On each cycle with iwait=0: data[idx][counter] <= iload and counter++.
//    On the word where counter==BLOCK_WORDS-1 and iwait=0: write tag, set valid, counter wraps to 0,
//    and go to IDLE. The next cycle hits when the address is unchanged.
//  - Miss latency: sum of the per-word memory latencies, plus 1 cycle to re-evaluate in IDLE.
//  - If imemREN drops or imemaddr changes mid-refill, the refill still completes and installs the
//    line. The new address is evaluated only in IDLE.
//  - Replacing a valid line overwrites it; the line is never partially valid.
//  - The refill always starts at word 0 (no critical-word-first).
// CONFIGURATION
//  ICACHE_PERF_EN defined:
//    - Adds outputs hit_count and miss_count, 32 bits each, reset to 0.
//    - hit_count increments on every cycle with ihit=1.
//    - miss_count increments on every IDLE->REFILL transition.
//    - Both counters saturate at 32'hFFFF_FFFF.
//  ICACHE_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package caches_pkg:
//    - icache_state_t enum {IDLE, REFILL}
//    - icache_frame_t struct {valid, tag, data[BLOCK_WORDS]}
//    - address-field width localparams derived from SETS/BLOCK_WORDS
//    - word_t from isa_pkg
//  - Sub-module icache_refill_fsm holds the state, counter, miss tag/index latch and iREN/iaddr
//    generation. It outputs a word-write strobe and a line-install strobe.
//  - The top level holds the frame array, hit compare and output mux.
// TESTING
//  1 Cold miss, SETS=16, BLOCK_WORDS=2, iwait=1 for 2 cycles per word:
//    imemaddr=0x0000_0040 ->
//      - iaddr=0x40, then 0x44
//      - ihit=0 during the refill
//      - ihit=1 with imemload=word@0x40 exactly 1 cycle after the second word is accepted
//  2 Spatial hit: after test 1, imemaddr=0x44 -> ihit=1 the same cycle, with no iREN.
//  3 Conflict: fetch 0x40, then 0x0000_00C0 (same idx=8, new tag) ->
//      - refill issues iaddr 0xC0 and 0xC4
//      - a later fetch of 0x40 misses again
//  4 Address change mid-refill: switch imemaddr to 0x100 after the first word ->
//      - the 0x40 line still completes and installs
//      - then a refill of 0x100 starts
//  5 Reset mid-refill: RST=1 while iREN=1 ->
//      - iREN=0 immediately (asynchronous)
//      - a refetch of 0x40 misses again
//  6 ICACHE_PERF_EN: 3 misses and 5 hit cycles -> miss_count=3 and hit_count=5; counter preloaded
//    at 32'hFFFF_FFFF does not wrap.

Source files
------------

// File: rtl/caches_pkg.sv
// Instruction cache geometry, address-field widths, state and frame types.
// Geometry lives here so every cache file agrees on field widths.
package caches_pkg;
    typedef isa_pkg::word_t word_t;

    localparam int ICACHE_SETS        = 16;
    localparam int ICACHE_BLOCK_WORDS = 2;

    localparam int WOFF_W = $clog2(ICACHE_BLOCK_WORDS);
    localparam int IDX_W  = $clog2(ICACHE_SETS);
    localparam int TAG_W  = 32 - 2 - WOFF_W - IDX_W;
    // Counter keeps one bit even for single-word lines
    localparam int CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
        word_t [ICACHE_BLOCK_WORDS-1:0] data;
    } icache_frame_t;

    function automatic word_t line_addr(
        input tag_t t,
        input idx_t i,
        input cnt_t c
    );
        word_t a;
        a = '0;
        a[31 -: TAG_W] = t;
        a[2+WOFF_W +: IDX_W] = i;
        if (WOFF_W > 0) a[2 +: CNT_W] = c;
        return a;
    endfunction
endpackage

// File: rtl/isa_pkg.sv
// ISA-wide base types shared by the core and its caches.
package isa_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = cache view, master = datapath/memory environment view.
interface icache_direct_mapped_if;
    import caches_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_refill_fsm.sv
// Miss handling: latches the missing line and fetches it word by word,
// emitting per-word write strobes and a final line-install strobe.
module icache_refill_fsm
    import caches_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  miss,
    input  tag_t  req_tag,
    input  idx_t  req_idx,
    input  logic  iwait,
    output logic  iren,
    output word_t iaddr,
    output logic  busy,
    output logic  start,
    output logic  word_we,
    output logic  line_we,
    output tag_t  wr_tag,
    output idx_t  wr_idx,
    output cnt_t  wr_cnt
);
    localparam cnt_t LAST = cnt_t'(ICACHE_BLOCK_WORDS - 1);

    icache_state_t state_q, state_d;
    cnt_t cnt_q, cnt_d;
    tag_t mtag_q, mtag_d;
    idx_t midx_q, midx_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mtag_q  <= '0;
            midx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mtag_q  <= mtag_d;
            midx_q  <= midx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mtag_d  = mtag_q;
        midx_d  = midx_q;
        iren    = 1'b0;
        iaddr   = '0;
        start   = 1'b0;
        word_we = 1'b0;
        line_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    start   = 1'b1;
                    mtag_d  = req_tag;
                    midx_d  = req_idx;
                    cnt_d   = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                iren  = 1'b1;
                iaddr = line_addr(mtag_q, midx_q, cnt_q);
                if (!iwait) begin
                    word_we = 1'b1;
                    if (cnt_q == LAST) begin
                        line_we = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == REFILL);
    assign wr_tag = mtag_q;
    assign wr_idx = midx_q;
    assign wr_cnt = cnt_q;
endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with zero-latency hits.
// Define ICACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module icache_direct_mapped
    import caches_pkg::*;
(
    input logic CLK,
    input logic RST,
    icache_direct_mapped_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output word_t hit_count,
    output word_t miss_count
`endif
);
    icache_frame_t frames [ICACHE_SETS];

    tag_t req_tag;
    idx_t req_idx;
    cnt_t req_woff;
    logic lookup;
    logic hit;
    logic busy;
    logic start;
    logic word_we;
    logic line_we;
    tag_t wr_tag;
    idx_t wr_idx;
    cnt_t wr_cnt;
    logic iren;
    word_t iaddr;
    logic unused_boff;

    assign req_tag = bus.imemaddr[31 -: TAG_W];
    assign req_idx = bus.imemaddr[2+WOFF_W +: IDX_W];
    assign unused_boff = ^bus.imemaddr[1:0];

    generate
        if (WOFF_W > 0) begin : g_woff
            assign req_woff = bus.imemaddr[2 +: CNT_W];
        end else begin : g_nowoff
            assign req_woff = '0;
        end
    endgenerate

    assign lookup = bus.imemREN
                  & frames[req_idx].valid
                  & (frames[req_idx].tag == req_tag);
    // Lookups are only honoured in IDLE; a refill masks every hit
    assign hit = lookup & ~busy;

    icache_refill_fsm u_fsm (
        .CLK     (CLK),
        .RST     (RST),
        .miss    (bus.imemREN & ~lookup),
        .req_tag (req_tag),
        .req_idx (req_idx),
        .iwait   (bus.iwait),
        .iren    (iren),
        .iaddr   (iaddr),
        .busy    (busy),
        .start   (start),
        .word_we (word_we),
        .line_we (line_we),
        .wr_tag  (wr_tag),
        .wr_idx  (wr_idx),
        .wr_cnt  (wr_cnt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ICACHE_SETS; i++)
                frames[i].valid <= 1'b0;
        end else begin
            if (word_we)
                frames[wr_idx].data[wr_cnt] <= bus.iload;
            if (line_we) begin
                frames[wr_idx].tag   <= wr_tag;
                frames[wr_idx].valid <= 1'b1;
            end
        end
    end

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? frames[req_idx].data[req_woff] : '0;
    assign bus.iREN     = iren;
    assign bus.iaddr    = iaddr;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (start && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule
